// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, in-order imem request/response handling and a
// DEPTH-entry queue ahead of decode. Define IF_PERF_CNT_EN to add dequeue/bubble counters.
module if_fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_decode,
  input  logic             pcsrc_decode,
  input  logic [WIDTH-1:0] pc_jump,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic             stall_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] instr_fetch,
`ifdef IF_PERF_CNT_EN
  output logic [WIDTH-1:0] pc_fetch,
  output logic [31:0]      perf_instr_cnt,
  output logic [31:0]      perf_bubble_cnt
`else
  output logic [WIDTH-1:0] pc_fetch
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [WIDTH-1:0] fpc;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] q_instr [DEPTH];
  logic [WIDTH-1:0] q_pc    [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    drop;

  logic             redir;
  logic [WIDTH-1:0] target;
  logic [CW:0]      occupancy;
  logic             req_fire;
  logic             enq;
  logic             deq;
  logic             head_valid;

  assign redir      = jump_decode | pcsrc_decode;
  assign target     = jump_decode ? pc_jump : pc_branch;
  assign occupancy  = {1'b0, count} + {1'b0, inflight};
  assign head_valid = (count != '0);

  // Requests are credit-limited so every accepted response is guaranteed a queue slot.
  assign imem_req_valid = rst && !redir && (occupancy < DEPTH_C);
  assign imem_addr      = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign enq         = imem_rsp_valid && !redir && (drop == '0);
  assign fetch_valid = head_valid && !redir;
  assign deq         = fetch_valid && !stall_pc;
  assign instr_fetch = head_valid ? q_instr[rd_ptr] : '0;
  assign pc_fetch    = head_valid ? q_pc[rd_ptr] : '0;

  // epc tracks the address of the next kept response, so the queue needs no address FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc      <= RESET_PC;
      epc      <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redir) begin
      fpc      <= target;
      epc      <= target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop     <= drop + inflight - CW'(imem_rsp_valid);
      inflight <= '0;
    end else begin
      if (req_fire)
        fpc <= fpc + PC_STEP;
      if (enq) begin
        epc    <= epc + PC_STEP;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)
        count <= count + 1'b1;
      else if (!enq && deq)
        count <= count - 1'b1;
      if (imem_rsp_valid && (drop != '0))
        drop <= drop - 1'b1;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid && (drop == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_instr[wr_ptr] <= imem_rsp_data;
      q_pc[wr_ptr]    <= epc + PC_STEP;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_instr_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (deq)
        perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (!fetch_valid && !stall_pc)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a fixed-latency in-order memory model, a program-order
// expected stream cleared on redirects, and a negedge monitor that pops on every dequeue.
`timescale 1ns/1ps
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_decode, pcsrc_decode, stall_pc;
  logic [31:0] pc_jump, pc_branch;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_valid;
  logic [31:0] instr_fetch, pc_fetch;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_instr_cnt, perf_bubble_cnt;
`endif

  if_fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .jump_decode(jump_decode), .pcsrc_decode(pcsrc_decode),
    .pc_jump(pc_jump), .pc_branch(pc_branch), .stall_pc(stall_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .fetch_valid(fetch_valid), .instr_fetch(instr_fetch),
`ifdef IF_PERF_CNT_EN
    .pc_fetch(pc_fetch), .perf_instr_cnt(perf_instr_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`else
    .pc_fetch(pc_fetch)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  exp_t        sb[$];
  mem_t        memq[$];
  int          cyc = -1;
  int          lat = 1;
  logic [31:0] model_fpc = 32'h0;
  int          fire_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          first_fv_cyc = -1;
  int          exp_deq = 0;
  int          exp_bubble = 0;
  logic        last_fv, last_req;
  logic [31:0] last_pc, last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: memory returns due responses, inputs are driven, then request
  // acceptance is checked and the expected program-order stream is extended.
  task automatic applyStimulus(input logic rdy, input logic stl, input logic jmp, input logic br,
                               input logic [31:0] pj, input logic [31:0] pb);
    @(posedge clk);
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end
    imem_req_ready = rdy;
    stall_pc       = stl;
    jump_decode    = jmp;
    pcsrc_decode   = br;
    pc_jump        = pj;
    pc_branch      = pb;
    #1;
    last_fv   = fetch_valid;
    last_pc   = pc_fetch;
    last_req  = imem_req_valid;
    last_addr = imem_addr;
    checkOutput("req_valid", imem_req_valid, !(jmp || br) && (sb.size() < DEPTH));
    if (jmp || br) begin
      model_fpc = jmp ? pj : pb;
      sb.delete();
    end else if (imem_req_valid && rdy) begin
      checkOutput("imem_addr", imem_addr, model_fpc);
      sb.push_back('{instr: mem_word(model_fpc), pc: model_fpc + 32'd4});
      memq.push_back('{addr: imem_addr, due: cyc + lat});
      model_fpc = model_fpc + 32'd4;
      fire_cnt++;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (jump_decode || pcsrc_decode)
        checkOutput("fetch_valid_in_redirect", fetch_valid, 0);
      if (!stall_pc) begin
        if (fetch_valid) exp_deq++;
        else exp_bubble++;
      end
      if (fetch_valid && first_fv_cyc < 0)
        first_fv_cyc = cyc;
      if (fetch_valid && !stall_pc) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_fetch: got fetch_valid=1 pc_fetch=0x%08h expected nothing pending (cycle %0d)",
                   pc_fetch, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("instr_fetch", instr_fetch, e.instr);
          checkOutput("pc_fetch", pc_fetch, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  f0, r, n, rv;
    bit  seen;
    rst = 1'b0;
    jump_decode = 1'b0; pcsrc_decode = 1'b0; stall_pc = 1'b0;
    pc_jump = '0; pc_branch = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_valid", imem_req_valid, 0);
    checkOutput("reset_fetch_valid", fetch_valid, 0);
    checkOutput("reset_instr", instr_fetch, 0);
    checkOutput("reset_pc_fetch", pc_fetch, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] sequential fetch, L=1");
    n = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      if (i >= 2) n += int'(last_fv);
    end
    checkOutput("first_fetch_cycle", first_fv_cyc, 2);
    checkOutput("full_throughput", n, 8);

    $display("[TB] sustained stall after redirect");
    applyStimulus(1, 1, 1, 0, 32'h40, 0);
    f0 = fire_cnt;
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("stall_fires", fire_cnt - f0, 4);
    checkOutput("stall_req_low", last_req, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      n += int'(last_fv);
    end
    checkOutput("drain_no_gaps", n, 4);

    $display("[TB] branch with requests in flight, L=3");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    lat = 3;
    f0 = fire_cnt;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("l3_fires", fire_cnt - f0, 3);
    applyStimulus(1, 0, 0, 1, 0, 32'h100);
    r = cyc;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      if (last_fv) begin
        seen = 1;
        checkOutput("branch_first_pc", last_pc, 32'h104);
        checkOutput("branch_latency", cyc - r, 5);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL branch_timeout: got no fetch_valid expected one within 12 cycles");
    end

    $display("[TB] jump wins over branch");
    applyStimulus(1, 0, 1, 1, 32'h200, 32'h100);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("jump_priority_req", last_req, 1);
    checkOutput("jump_priority_addr", last_addr, 32'h200);

    $display("[TB] fetch address wrap");
    applyStimulus(1, 0, 1, 0, 32'hFFFF_FFFC, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wrap_top_addr", last_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wrap_addr", last_addr, 32'h0);

    $display("[TB] randomized traffic");
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      lat = $urandom_range(1, 3);
      for (int i = 0; i < 300; i++) begin
        rv = $urandom_range(0, 99);
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      rv < 3, (rv >= 2 && rv < 6),
                      $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
      end
    end

    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("all_delivered", sb.size(), 0);
    checkOutput("drained_fetch_valid", last_fv, 0);
    checkOutput("drained_instr", instr_fetch, 0);
    checkOutput("drained_pc_fetch", pc_fetch, 0);
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_instr_cnt", perf_instr_cnt, exp_deq);
    checkOutput("perf_bubble_cnt", perf_bubble_cnt, exp_bubble);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
